kbd_disp_ctrl: RTL

KBD_DISP_CTRL -- requirements
Module: kbd_disp_ctrl

---
 rtl/kbd_pkg.sv | 15 +
 rtl/kbd_disp_ctrl_if.sv | 21 ++
 rtl/kbd_disp_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// Shared types and scan-code constants for the
// PS/2 keyboard display controller.
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

endpackage

// File: rtl/kbd_disp_ctrl_if.sv
// Scan-byte valid/ready channel between the PS/2
// receiver and the display controller.
interface kbd_disp_ctrl_if;

  logic       kb_valid;
  logic [7:0] kb_data;
  logic       kb_ready;

  modport master (
    output kb_valid,
    output kb_data,
    input  kb_ready
  );

  modport slave (
    input  kb_valid,
    input  kb_data,
    output kb_ready
  );

endinterface

// File: rtl/kbd_disp_ctrl.sv
// Decodes PS/2 set-2 scan bytes into the held key
// shown on the seven-segment pair.
module kbd_disp_ctrl
  import kbd_pkg::*;
#(
  parameter logic [23:0] TIMEOUT = 24'd5_000_000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       kb_valid,
  input  logic [7:0] kb_data,
  output logic       kb_ready,
  output logic [7:0] disp_code,
  output logic       disp_light,
  output logic [7:0] key_cnt,
  output logic       ext
);

  state_t      state, state_n;
  logic [23:0] tcnt, tcnt_n;
  logic        held, held_n;
  logic [7:0]  code_n, cnt_n;
  logic        ext_n;
  logic        fire;
  logic        is_ext, is_brk;
  logic        brk_flag;
  logic        same_mk;

  assign fire       = kb_valid & kb_ready;
  assign is_ext     = (kb_data == CODE_EXT);
  assign is_brk     = (kb_data == CODE_BRK);
  assign brk_flag   = (state == EXT_BRK);
  assign disp_light = held;

  // A make matches the held key when code and the
  // extension flag implied by the state both agree.
  assign same_mk = held && (kb_data == disp_code)
                   && (ext == (state == EXT));

  // Next state, timeout and display updates.
  always_comb begin
    state_n = state;
    tcnt_n  = (state == IDLE) ? 24'd0 : tcnt + 24'd1;
    held_n  = held;
    code_n  = disp_code;
    ext_n   = ext;
    cnt_n   = key_cnt;
    if (fire) begin
      tcnt_n = 24'd0;
      unique case (state)
        IDLE, EXT: begin
          unique case (1'b1)
            is_brk: state_n = (state == EXT) ? EXT_BRK : BRK;
            is_ext: state_n = EXT;
            default: begin
              state_n = IDLE;
              if (!same_mk) begin
                code_n = kb_data;
                ext_n  = (state == EXT);
                held_n = 1'b1;
                cnt_n  = key_cnt + 8'd1;
              end
            end
          endcase
        end
        BRK, EXT_BRK: begin
          state_n = IDLE;
          if (held && kb_data == disp_code
              && ext == brk_flag) begin
            held_n = 1'b0;
            ext_n  = 1'b0;
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE
                 && tcnt == TIMEOUT - 24'd1) begin
      state_n = IDLE;
      tcnt_n  = 24'd0;
    end
  end

  // State, timeout and registered outputs.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= IDLE;
      tcnt      <= 24'd0;
      held      <= 1'b0;
      disp_code <= 8'h00;
      key_cnt   <= 8'h00;
      ext       <= 1'b0;
      kb_ready  <= 1'b0;
    end else begin
      state     <= state_n;
      tcnt      <= tcnt_n;
      held      <= held_n;
      disp_code <= code_n;
      key_cnt   <= cnt_n;
      ext       <= ext_n;
      kb_ready  <= ~fire;
    end
  end

endmodule
